gpu_rect_engine: RTL and testbench
==================================

// Module: gpu_rect_engine
// PURPOSE
//   Parametrised rectangle rasteriser for the brus16 video path: streams a rectangle table into a
//   shadow bank, swaps it into the active bank during blanking, and emits one pixel colour per
//   pixel_clk for the incoming (x_coord, y_coord) beam position. Sits between the VGA timing
//   generator and the DAC. Adds to the previous gpu: double-buffered table, per-rect enable,
//   background colour and a fixed 3-stage hit-test pipeline.
// PARAMETERS
//   RECTS     64       number of rectangle slots (power of 2, 2..128)
//   COORD_W   16       coordinate/size width (unsigned)
//   COLOR_W   16       colour width
//   BG_COLOR  16'h0000 colour emitted when no enabled rect covers the pixel
// PORTS
//   pixel_clk  in   1        sole clock, all logic on rising edge
//   reset      in   1        asynchronous, active-low reset
//   we         in   1        mem_din holds the next table word this cycle
//   mem_din    in   16       table word (low COORD_W/COLOR_W bits used)
//   load_start in   1        restart shadow write pointer at rect 0, word 0
//   idle       in   1        blanking interval; bank swap allowed
//   x_coord    in   COORD_W  beam x
//   y_coord    in   COORD_W  beam y
//   color      out  COLOR_W  pixel colour, 3 cycles after x/y
//   pending    out  1        complete shadow table waiting for swap
//   swapped    out  1        1-cycle pulse: active bank just updated
// BEHAVIOUR
//   Record: 6 words per rect: 0 left, 1 top, 2 width, 3 height, 4 colour, 5 flags (bit0 = enable).
//   Load: write pointer (rect_idx, word_idx) advances only on cycles with we=1; word 5 -> next rect.
//   - Word 2/3 stored as right=left+width, bottom=top+height in COORD_W+1 bits (no wrap).
//   - After word 5 of rect RECTS-1: pointer wraps to 0/0, pending<=1 next cycle.
//   - we=0 mid-record: pointer holds; no timeout.
//   - load_start=1: pointer <=0/0, pending<=0; beats we in the same cycle (that word is written
//     as word 0 of rect 0, pointer -> 0/1).
//   - Any we write while pending=1 clears pending (new table in progress).
//   Swap: cycle with idle=1 && pending=1 -> all shadow records copied to active bank on that edge,
//     pending<=0, swapped=1 for one cycle. Last word written in an idle cycle -> swap on the
//     following idle cycle earliest. idle=0 -> pending held indefinitely.
//   Hit test pipeline (always running, independent of load):
//   - S1: register x_coord/y_coord.
//   - S2: hit[i] = en[i] & left<=x<right & top<=y<bottom (unsigned, right/bottom exclusive).
//     width or height 0 -> never hits.
//   - S3: highest set index wins; color <= its colour, else BG_COLOR.
//   - Latency exactly 3 pixel_clk; throughput 1 pixel/cycle; swap takes effect for S2 on the
//     cycle after the swap edge (no mixed-bank pixel).
//   Reset (reset=0, async): both banks all-zero (all rects disabled), pointer 0/0, pending=0,
//     swapped=0, pipeline regs 0, color=BG_COLOR. Reset mid-load discards the partial table.
// TESTING
//   1 Reset, no load, sweep x=0..9 -> color=BG_COLOR every cycle; pending=0.
//   2 Load rect0 {10,10,5,5,0xF800,1}, other rects en=0, then idle=1 -> pending=1 after the last
//     word, swapped pulse once; (12,12) -> 0xF800 three cycles later; (15,12) -> BG_COLOR.
//   3 Overlap: rect3 {0,0,100,100,0x07E0,1}, rect40 {50,50,10,10,0x001F,1}; (55,55) -> 0x001F,
//     (49,55) -> 0x07E0.
//   4 Double buffer: with rect0 red active, stream table with rect0 colour 0x001F while idle=0 ->
//     output stays 0xF800; raise idle -> 0x001F from 1 cycle after swapped.
//   5 Edges: left=0xFFF0 width=0x20 -> x=0xFFFF hits, x=0 misses; en=0 rect never hits;
//     width=0 never hits.
//   6 we gaps/load_start mid-table -> pointer restarts, pending stays 0 until full 6*RECTS
//     words; async reset mid-stream -> color=BG_COLOR, pending=0.

Source files
------------

// File: rtl/gpu_rect_engine.sv
// Rectangle rasteriser: double-buffered rectangle table loaded word by word,
// 3-stage hit-test pipeline emitting one colour per pixel_clk.
module gpu_rect_engine #(
   parameter int unsigned        RECTS    = 64,
   parameter int unsigned        COORD_W  = 16,
   parameter int unsigned        COLOR_W  = 16,
   parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(16'h0000)
) (
   input  logic               pixel_clk,
   input  logic               reset,
   input  logic               we,
   input  logic [15:0]        mem_din,
   input  logic               load_start,
   input  logic               idle,
   input  logic [COORD_W-1:0] x_coord,
   input  logic [COORD_W-1:0] y_coord,
   output logic [COLOR_W-1:0] color,
   output logic               pending,
   output logic               swapped
);

   localparam int unsigned IDX_W     = $clog2(RECTS);
   localparam int unsigned WORD_W    = 3;
   localparam int unsigned LAST_WORD = 5;

   typedef struct packed {
      logic               en;
      logic [COLOR_W-1:0] col;
      logic [COORD_W:0]   bot;
      logic [COORD_W:0]   rgt;
      logic [COORD_W-1:0] top;
      logic [COORD_W-1:0] lft;
   } rect_t;

   rect_t shadow_q [RECTS];
   rect_t shadow_d [RECTS];
   rect_t active_q [RECTS];
   rect_t active_d [RECTS];

   logic [IDX_W-1:0]   rect_idx_q, rect_idx_d;
   logic [WORD_W-1:0]  word_idx_q, word_idx_d;
   logic               pending_q, pending_d;
   logic               swapped_q, swapped_d;
   logic [COORD_W-1:0] x_s1_q, x_s1_d, y_s1_q, y_s1_d;
   logic [COLOR_W-1:0] col_s2_q, col_s2_d;
   logic [COLOR_W-1:0] color_q, color_d;

   logic [IDX_W-1:0]   wr_rect;
   logic [WORD_W-1:0]  wr_word;
   logic [COORD_W-1:0] din_coord;
   rect_t              wr_rec;

   // Table load, bank swap and pending/swapped bookkeeping.
   always_comb begin
      shadow_d   = shadow_q;
      active_d   = active_q;
      rect_idx_d = rect_idx_q;
      word_idx_d = word_idx_q;
      pending_d  = pending_q;
      swapped_d  = 1'b0;
      wr_rect    = load_start ? '0 : rect_idx_q;
      wr_word    = load_start ? '0 : word_idx_q;
      din_coord  = COORD_W'(mem_din);
      wr_rec     = shadow_q[wr_rect];

      if (idle && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
         swapped_d = 1'b1;
      end

      if (load_start) begin
         rect_idx_d = '0;
         word_idx_d = '0;
         pending_d  = 1'b0;
      end

      if (we) begin
         case (wr_word)
            WORD_W'(0): wr_rec.lft = din_coord;
            WORD_W'(1): wr_rec.top = din_coord;
            WORD_W'(2): wr_rec.rgt = (COORD_W+1)'(wr_rec.lft) + (COORD_W+1)'(din_coord);
            WORD_W'(3): wr_rec.bot = (COORD_W+1)'(wr_rec.top) + (COORD_W+1)'(din_coord);
            WORD_W'(4): wr_rec.col = COLOR_W'(mem_din);
            default:    wr_rec.en  = mem_din[0];
         endcase
         shadow_d[wr_rect] = wr_rec;
         pending_d         = 1'b0;
         if (wr_word == WORD_W'(LAST_WORD)) begin
            word_idx_d = '0;
            rect_idx_d = wr_rect + IDX_W'(1);
            if (wr_rect == IDX_W'(RECTS - 1)) begin
               pending_d = 1'b1;
            end
         end else begin
            word_idx_d = wr_word + WORD_W'(1);
         end
      end
   end

   // Hit test and priority select both resolve in S2 so a pixel never mixes banks.
   always_comb begin
      x_s1_d   = x_coord;
      y_s1_d   = y_coord;
      col_s2_d = BG_COLOR;
      for (int unsigned i = 0; i < RECTS; i++) begin
         if (active_q[i].en &&
             (x_s1_q >= active_q[i].lft) && ({1'b0, x_s1_q} < active_q[i].rgt) &&
             (y_s1_q >= active_q[i].top) && ({1'b0, y_s1_q} < active_q[i].bot)) begin
            col_s2_d = active_q[i].col;
         end
      end
      color_d = col_s2_q;
   end

   always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < RECTS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         rect_idx_q <= '0;
         word_idx_q <= '0;
         pending_q  <= 1'b0;
         swapped_q  <= 1'b0;
         x_s1_q     <= '0;
         y_s1_q     <= '0;
         col_s2_q   <= BG_COLOR;
         color_q    <= BG_COLOR;
      end else begin
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         rect_idx_q <= rect_idx_d;
         word_idx_q <= word_idx_d;
         pending_q  <= pending_d;
         swapped_q  <= swapped_d;
         x_s1_q     <= x_s1_d;
         y_s1_q     <= y_s1_d;
         col_s2_q   <= col_s2_d;
         color_q    <= color_d;
      end
   end

   assign color   = color_q;
   assign pending = pending_q;
   assign swapped = swapped_q;

endmodule

// File: tb/tb_gpu_rect_engine.sv
// Randomised bench for gpu_rect_engine: a word-level table model renders each
// pixel directly from rectangle geometry and is compared every cycle.
module tb_gpu_rect_engine;

   localparam int unsigned RECTS   = 64;
   localparam int unsigned COORD_W = 16;
   localparam int unsigned COLOR_W = 16;
   localparam logic [15:0] BG      = 16'h0000;

   logic               pixel_clk;
   logic               reset;
   logic               we;
   logic [15:0]        mem_din;
   logic               load_start;
   logic               idle;
   logic [COORD_W-1:0] x_coord;
   logic [COORD_W-1:0] y_coord;
   logic [COLOR_W-1:0] color;
   logic               pending;
   logic               swapped;

   gpu_rect_engine #(
      .RECTS   (RECTS),
      .COORD_W (COORD_W),
      .COLOR_W (COLOR_W),
      .BG_COLOR(BG)
   ) dut (
      .pixel_clk (pixel_clk),
      .reset     (reset),
      .we        (we),
      .mem_din   (mem_din),
      .load_start(load_start),
      .idle      (idle),
      .x_coord   (x_coord),
      .y_coord   (y_coord),
      .color     (color),
      .pending   (pending),
      .swapped   (swapped)
   );

   initial pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   int n_chk;
   int n_pass;

   // Reference: raw table words; geometry derived only when rendering.
   int unsigned tab [RECTS][6];
   int unsigned sh  [RECTS][6];
   int unsigned act [RECTS][6];
   int unsigned m_rect;
   int unsigned m_word;
   bit          m_pend;
   bit          m_swp;
   logic [15:0] exp_q [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [15:0] render(input int unsigned x, input int unsigned y);
      for (int r = int'(RECTS) - 1; r >= 0; r--) begin
         if (((act[r][5] & 1) != 0) &&
             x >= act[r][0] && x < act[r][0] + act[r][2] &&
             y >= act[r][1] && y < act[r][1] + act[r][3])
            return 16'(act[r][4]);
      end
      return BG;
   endfunction

   function automatic logic [15:0] rnd_coord();
      if ($urandom_range(0, 3) != 0) return 16'($urandom_range(0, 130));
      return 16'($urandom);
   endfunction

   // One clock: check outputs, drive inputs, advance the model over the coming edge.
   task automatic cyc(input logic w, input logic [15:0] d, input logic ls, input logic idl,
                      input logic [15:0] x, input logic [15:0] y);
      @(negedge pixel_clk);
      if (exp_q.size() >= 3) check_eq("color", 32'(color), 32'(exp_q.pop_front()));
      check_eq("pending", 32'(pending), 32'(m_pend));
      check_eq("swapped", 32'(swapped), 32'(m_swp));
      we = w; mem_din = d; load_start = ls; idle = idl; x_coord = x; y_coord = y;
      m_swp = idl && m_pend;
      if (m_swp) begin
         act    = sh;
         m_pend = 1'b0;
      end
      if (ls) begin
         m_rect = 0; m_word = 0; m_pend = 1'b0;
      end
      if (w) begin
         sh[m_rect][m_word] = int'(d);
         m_pend = 1'b0;
         if (m_word == 5) begin
            m_word = 0;
            if (m_rect == RECTS - 1) begin
               m_rect = 0;
               m_pend = 1'b1;
            end else m_rect++;
         end else m_word++;
      end
      exp_q.push_back(render(int'(x), int'(y)));
   endtask

   task automatic run(input int n, input logic idl);
      for (int k = 0; k < n; k++) cyc(1'b0, 16'($urandom), 1'b0, idl, rnd_coord(), rnd_coord());
   endtask

   task automatic pix(input logic [15:0] x, input logic [15:0] y, input logic idl);
      cyc(1'b0, 16'h0, 1'b0, idl, x, y);
   endtask

   task automatic do_reset();
      #3 reset = 1'b0;
      we = 1'b0; load_start = 1'b0; idle = 1'b0; mem_din = '0;
      for (int r = 0; r < int'(RECTS); r++)
         for (int w = 0; w < 6; w++) begin
            sh[r][w] = 0; act[r][w] = 0;
         end
      m_rect = 0; m_word = 0; m_pend = 1'b0; m_swp = 1'b0;
      exp_q.delete();
      #1;
      check_eq("rst_color", 32'(color), 32'(BG));
      check_eq("rst_pending", 32'(pending), 32'h0);
      check_eq("rst_swapped", 32'(swapped), 32'h0);
      repeat (2) @(negedge pixel_clk);
      check_eq("rst_hold_color", 32'(color), 32'(BG));
      reset = 1'b1;
   endtask

   // Disabled rects carry random geometry so only the enable bit keeps them invisible.
   task automatic clear_tab();
      for (int r = 0; r < int'(RECTS); r++) begin
         tab[r][0] = $urandom_range(0, 120);
         tab[r][1] = $urandom_range(0, 120);
         tab[r][2] = $urandom_range(0, 60);
         tab[r][3] = $urandom_range(0, 60);
         tab[r][4] = $urandom & 32'hFFFF;
         tab[r][5] = $urandom & 32'hFFFE;
      end
   endtask

   task automatic set_rect(input int r, input int unsigned l, input int unsigned t,
                           input int unsigned w, input int unsigned h,
                           input int unsigned c, input int unsigned en);
      tab[r][0] = l; tab[r][1] = t; tab[r][2] = w; tab[r][3] = h; tab[r][4] = c; tab[r][5] = en;
   endtask

   // Streams the first nwords of tab, load_start with the first word, random we gaps.
   task automatic load_table(input int nwords, input bit rnd_idle, input bit fixed_px,
                             input logic [15:0] fx, input logic [15:0] fy);
      logic [15:0] x;
      logic [15:0] y;
      for (int k = 0; k < nwords; k++) begin
         while ($urandom_range(0, 3) == 0) begin
            x = fixed_px ? fx : rnd_coord();
            y = fixed_px ? fy : rnd_coord();
            cyc(1'b0, 16'($urandom), 1'b0, rnd_idle ? 1'($urandom_range(0, 1)) : 1'b0, x, y);
         end
         x = fixed_px ? fx : rnd_coord();
         y = fixed_px ? fy : rnd_coord();
         cyc(1'b1, 16'(tab[k / 6][k % 6]), 1'(k == 0),
             rnd_idle ? 1'($urandom_range(0, 1)) : 1'b0, x, y);
      end
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      reset = 1'b1; we = 1'b0; mem_din = '0; load_start = 1'b0; idle = 1'b0;
      x_coord = '0; y_coord = '0;
      m_rect = 0; m_word = 0; m_pend = 1'b0; m_swp = 1'b0;

      // Empty banks after reset: background everywhere.
      do_reset();
      for (int x = 0; x < 10; x++) pix(16'(x), 16'h0, 1'b0);
      run(4, 1'b1);

      // Single red rect, swap during idle.
      clear_tab();
      set_rect(0, 10, 10, 5, 5, 32'hF800, 1);
      load_table(6 * int'(RECTS), 1'b0, 1'b0, 16'h0, 16'h0);
      run(3, 1'b0);
      pix(16'd12, 16'd12, 1'b1);
      pix(16'd12, 16'd12, 1'b1);
      pix(16'd15, 16'd12, 1'b1);
      pix(16'd14, 16'd14, 1'b1);
      pix(16'd12, 16'd15, 1'b1);
      run(6, 1'b1);

      // Overlap: higher index wins.
      set_rect(3, 0, 0, 100, 100, 32'h07E0, 1);
      set_rect(40, 50, 50, 10, 10, 32'h001F, 1);
      load_table(6 * int'(RECTS), 1'b0, 1'b0, 16'h0, 16'h0);
      pix(16'd55, 16'd55, 1'b1);
      pix(16'd55, 16'd55, 1'b0);
      pix(16'd49, 16'd55, 1'b0);
      pix(16'd59, 16'd59, 1'b0);
      pix(16'd60, 16'd59, 1'b0);
      run(150, 1'b0);

      // Double buffer: new table streamed with idle low leaves the active bank alone.
      clear_tab();
      set_rect(0, 10, 10, 5, 5, 32'hF800, 1);
      load_table(6 * int'(RECTS), 1'b0, 1'b0, 16'h0, 16'h0);
      run(2, 1'b1);
      set_rect(0, 10, 10, 5, 5, 32'h001F, 1);
      load_table(6 * int'(RECTS), 1'b0, 1'b1, 16'd12, 16'd12);
      for (int k = 0; k < 5; k++) pix(16'd12, 16'd12, 1'b0);
      for (int k = 0; k < 6; k++) pix(16'd12, 16'd12, 1'b1);

      // Edges: no wrap at the top of the range, disabled and zero-width rects.
      clear_tab();
      set_rect(5, 32'hFFF0, 0, 32'h20, 32'h100, 32'h1234, 1);
      set_rect(6, 0, 0, 200, 200, 32'h5555, 0);
      set_rect(7, 0, 0, 0, 200, 32'h6666, 1);
      set_rect(8, 20, 20, 30, 0, 32'h7777, 1);
      load_table(6 * int'(RECTS), 1'b0, 1'b0, 16'h0, 16'h0);
      pix(16'hFFFF, 16'd5, 1'b1);
      pix(16'hFFFF, 16'd5, 1'b0);
      pix(16'h0000, 16'd5, 1'b0);
      pix(16'hFFEF, 16'd5, 1'b0);
      pix(16'd100, 16'd100, 1'b0);
      pix(16'd25, 16'd20, 1'b0);
      run(8, 1'b0);

      // Random tables with idle toggling during the stream.
      for (int t = 0; t < 2; t++) begin
         clear_tab();
         for (int k = 0; k < 8; k++)
            set_rect(int'($urandom_range(0, RECTS - 1)), $urandom_range(0, 100),
                     $urandom_range(0, 100), $urandom_range(0, 40), $urandom_range(0, 40),
                     $urandom & 32'hFFFF, 1);
         load_table(6 * int'(RECTS), 1'b1, 1'b0, 16'h0, 16'h0);
         run(100, 1'b1);
      end

      // Partial stream then restart: pending only after a full table.
      clear_tab();
      set_rect(9, 30, 30, 20, 20, 32'hABCD, 1);
      load_table(100, 1'b1, 1'b0, 16'h0, 16'h0);
      run(5, 1'b1);
      load_table(6 * int'(RECTS), 1'b0, 1'b0, 16'h0, 16'h0);
      pix(16'd35, 16'd35, 1'b1);
      run(10, 1'b0);

      // Reset mid-stream discards everything.
      load_table(50, 1'b0, 1'b0, 16'h0, 16'h0);
      do_reset();
      pix(16'd35, 16'd35, 1'b1);
      run(10, 1'b1);
      load_table(6 * int'(RECTS), 1'b0, 1'b0, 16'h0, 16'h0);
      pix(16'd35, 16'd35, 1'b1);
      run(6, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
